fpa_controller: RTL
===================

Name: fpa_controller

Overview:
- Sequencing FSM that drives the floating-point adder datapath: issues register enables and mux selects for the LOAD, ADD and NORMALIZE stages and the final result capture.
- Accepts a start request, monitors the datapath's mantissa and exception status, and iterates single-bit normalization shifts until the result is normalized, zero, or an exception occurs.
- Sits between the top-level wrapper (start/done handshake) and the datapath (enables/selects out, status in).

Parameters:
- MAX_NORM, 4, maximum normalization shifts per operation before a shift-limit exception.
- CNT_W, 3, width of the shift counter; must hold MAX_NORM.

Ports:
- clk  input  1  system clock, rising-edge.
- clr  input  1  reset, asynchronous, active-high.
- start  input  1  operation request; sampled in IDLE only.
- mant  input  5  datapath mantissa; bits [4:3] are carry/hidden bits.
- add_except  input  1  datapath add-stage exception.
- norm_except  input  1  datapath normalize-stage exception (exponent all-ones).
- load_en  output  1  load-stage register enable.
- add_en  output  1  add-stage register enable.
- norm_en  output  1  normalize-stage register enable.
- norm_load  output  1  normalize mux: 1 = load from add stage, 0 = shifted value.
- shift_right  output  1  normalize shift direction: 1 = right/exp+1, 0 = left/exp-1.
- mant_sel  output  1  datapath mant mux: 1 = normalize-stage mantissa, 0 = add-stage mantissa.
- done_en  output  1  result register enable.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse when the result is captured.
- zero_result  output  1  result mantissa was zero; valid with done, held until next accepted start.
- except_code  output  2  00 none, 01 add exception, 10 normalize exception, 11 shift limit; valid with done, held until next accepted start.

Behaviour:
- Reset: state=IDLE; shift count=0; dir=0; all outputs 0, including except_code=00 and zero_result=0.
- Reset is asynchronous. Asserting clr mid-operation aborts immediately to IDLE with all outputs 0; no done pulse is generated.
- States (3-bit encoding): IDLE=0, LOAD=1, ADD=2, NLOAD=3, NEVAL=4, NSHIFT=5, DONE=6. The unused code 7 returns to IDLE.
- Enables are Moore outputs decoded from the state register only. There is no combinational path from mant or the exception inputs to any output.
- IDLE: all enables 0. start=1 moves to LOAD. start is ignored while busy.
- LOAD: load_en=1; clear except_code, zero_result and shift count. Next state ADD.
- ADD: add_en=1. Next state NLOAD.
- NLOAD: norm_en=1, norm_load=1. Sample add_except: if 1, set except_code=01 and go to DONE; otherwise go to NEVAL.
- NEVAL: mant_sel=1, no enables asserted. Decisions in priority order:
  1. norm_except=1 -> except_code=10, DONE.
  2. mant==0 -> zero_result=1, DONE.
  3. mant[4:3]==01 -> DONE (normalized).
  4. count==MAX_NORM -> except_code=11, DONE.
  5. mant[4]=1 -> dir=1 (right), NSHIFT.
  6. otherwise -> dir=0 (left), NSHIFT.
- NSHIFT: norm_en=1, norm_load=0, mant_sel=1, shift_right=dir (registered, stable for the whole cycle). count increments. Next state NEVAL.
- DONE: done_en=1, done=1 for exactly one cycle. Next state IDLE.
- A start held high through DONE begins a new operation on the cycle after DONE, i.e. IDLE is spent for 1 cycle.
- Latency, with start sampled at edge 0: LOAD in cycle 1, ADD 2, NLOAD 3, NEVAL 4, DONE at cycle 5 with no shifts. Each shift adds 2 cycles. Worst case is DONE at cycle 5+2*MAX_NORM=13.
- Counter arithmetic is unsigned CNT_W bits and never wraps; the bound check in NEVAL precedes any increment.
- Simultaneous conditions: norm_except has priority over zero and over normalization; add_except in NLOAD skips NEVAL entirely.

Test Plan:
- Reset during NSHIFT (clr pulse mid-cycle) -> all outputs 0 asynchronously, state=IDLE; first start afterwards completes normally.
- start=1, mant=5'b01010 at NEVAL, no exceptions -> load_en, add_en and norm_en+norm_load asserted in cycles 1, 2 and 3 respectively; done=1, done_en=1 in cycle 5; except_code=00; busy high in cycles 1-5.
- mant=5'b10110 at first NEVAL, then 5'b01011 -> one NSHIFT with shift_right=1, norm_en=1; done in cycle 7; except_code=00.
- mant=5'b00010, then 5'b00100, then 5'b01000 -> two NSHIFTs with shift_right=0; done in cycle 9.
- mant stuck at 5'b00001 -> four NSHIFTs, then except_code=11 and done in cycle 13; a fifth NSHIFT never occurs.
- add_except=1 in NLOAD -> except_code=01, done in cycle 4, NEVAL never entered.
- mant=0 at NEVAL -> zero_result=1, done in cycle 5.
- norm_except=1 together with mant=5'b01000 at NEVAL -> except_code=10 takes priority, done in cycle 5.
- start pulsed while busy -> ignored, exactly one done pulse.

Source files
------------

// File: rtl/fpa_controller.sv
// Sequencing FSM for the floating-point adder datapath.
// Ports: clk/clr, start, mant/add_except/norm_except status in;
// load_en/add_en/norm_en/norm_load/shift_right/mant_sel/done_en,
// busy/done/zero_result/except_code out (all registered).
module fpa_controller #(
  parameter int MAX_NORM = 4,
  parameter int CNT_W    = 3
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       start,
  input  logic [4:0] mant,
  input  logic       add_except,
  input  logic       norm_except,
  output logic       load_en,
  output logic       add_en,
  output logic       norm_en,
  output logic       norm_load,
  output logic       shift_right,
  output logic       mant_sel,
  output logic       done_en,
  output logic       busy,
  output logic       done,
  output logic       zero_result,
  output logic [1:0] except_code
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    ADD    = 3'd2,
    NLOAD  = 3'd3,
    NEVAL  = 3'd4,
    NSHIFT = 3'd5,
    DONE   = 3'd6
  } state_t;

  state_t             state;
  state_t             nxt;
  logic               dir;
  logic               nxt_dir;
  logic [CNT_W-1:0]   count;
  logic               at_limit;

  assign at_limit = (count == CNT_W'(MAX_NORM));

  always_comb begin
    nxt     = state;
    nxt_dir = dir;
    unique case (state)
      IDLE:   nxt = start ? LOAD : IDLE;
      LOAD:   nxt = ADD;
      ADD:    nxt = NLOAD;
      NLOAD:  nxt = add_except ? DONE : NEVAL;
      NEVAL: begin
        if (norm_except)           nxt = DONE;
        else if (mant == 5'd0)     nxt = DONE;
        else if (mant[4:3] == 2'b01) nxt = DONE;
        else if (at_limit)         nxt = DONE;
        else begin
          nxt     = NSHIFT;
          nxt_dir = mant[4];
        end
      end
      NSHIFT: nxt = NEVAL;
      DONE:   nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so that they are
  // registered yet line up with the state they belong to.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state       <= IDLE;
      dir         <= 1'b0;
      count       <= '0;
      load_en     <= 1'b0;
      add_en      <= 1'b0;
      norm_en     <= 1'b0;
      norm_load   <= 1'b0;
      shift_right <= 1'b0;
      mant_sel    <= 1'b0;
      done_en     <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      zero_result <= 1'b0;
      except_code <= 2'b00;
    end else begin
      state       <= nxt;
      dir         <= nxt_dir;
      load_en     <= (nxt == LOAD);
      add_en      <= (nxt == ADD);
      norm_en     <= (nxt == NLOAD) || (nxt == NSHIFT);
      norm_load   <= (nxt == NLOAD);
      shift_right <= (nxt == NSHIFT) && nxt_dir;
      mant_sel    <= (nxt == NEVAL) || (nxt == NSHIFT);
      done_en     <= (nxt == DONE);
      done        <= (nxt == DONE);
      busy        <= (nxt != IDLE);
      unique case (state)
        IDLE: begin
          if (start) begin
            except_code <= 2'b00;
            zero_result <= 1'b0;
            count       <= '0;
          end
        end
        NLOAD: begin
          if (add_except) except_code <= 2'b01;
        end
        NEVAL: begin
          if (norm_except)             except_code <= 2'b10;
          else if (mant == 5'd0)       zero_result <= 1'b1;
          else if (mant[4:3] == 2'b01) except_code <= except_code;
          else if (at_limit)           except_code <= 2'b11;
        end
        NSHIFT: count <= count + 1'b1;
        default: ;
      endcase
    end
  end

endmodule
